// File: rtl/sdram_dev_model.sv
// SDRAM device-side responder: decodes controller commands, keeps a small
// array, returns read data after the programmed CAS latency and latches the
// first protocol error seen since reset.
//
// Bank state | meaning
// -----------+-----------------------------------------------
// CLOSED     | no row latched; READ/WRITE here is an error
// OPEN       | row latched by ACTIVE; age counter running
module sdram_dev_model #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4,
    parameter int TRCD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_addr,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] sdram_dq_i,
    output logic [15:0] sdram_dq_o,
    output logic        sdram_dq_oe,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_cnt
);

    localparam int IDX_W = 2 + ROW_W + COL_W;
    localparam int DEPTH = 1 << IDX_W;
    // Age saturates at 15, which covers any practical TRCD.
    localparam int AGE_W = 4;

    typedef enum logic { BANK_CLOSED = 1'b0, BANK_OPEN = 1'b1 } bank_st_e;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    cmd_e             cmd;
    bank_st_e         bank_q [4];
    bank_st_e         bank_d [4];
    logic [ROW_W-1:0] row_q [4];
    logic [ROW_W-1:0] row_d [4];
    logic [AGE_W-1:0] age_q [4];
    logic [AGE_W-1:0] age_d [4];
    logic             mode_valid_q, mode_valid_d;
    logic             mode_cl3_q, mode_cl3_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [15:0]      refresh_q, refresh_d;
    logic [2:0]       pv_q, pv_d;
    logic [2:0]       pcl3_q, pcl3_d;
    logic [15:0]      pd_q [3];
    logic [15:0]      pd_d [3];
    logic             dq_oe_q, dq_oe_d;
    logic [15:0]      dq_o_q, dq_o_d;
    logic [15:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [15:0]      rd_word;
    logic             any_open, sel_open, age_ok, lm_legal;
    logic             rd_en, wr_en, raise;
    logic [2:0]       raise_code;
    logic             unused_addr;

    // Command decode; deselected or clock-disabled cycles are NOPs.
    always_comb begin
        cmd = CMD_NOP;
        if (sdram_cke && !sdram_cs_n) begin
            cmd = cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n});
        end
    end

    assign idx      = {sdram_ba, row_q[sdram_ba], sdram_addr[COL_W-1:0]};
    assign rd_word  = {sdram_dqm[1] ? 8'h00 : mem_q[idx][15:8],
                       sdram_dqm[0] ? 8'h00 : mem_q[idx][7:0]};
    assign sel_open = (bank_q[sdram_ba] == BANK_OPEN);
    // age is 0 on the cycle after ACTIVE, so access at edge A+k sees k-1.
    assign age_ok   = (int'(age_q[sdram_ba]) + 1) >= TRCD;
    assign lm_legal = ((sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3))
                      && (sdram_addr[2:0] == 3'b000);
    // Only some address bits matter to this model; the rest are aliased away.
    assign unused_addr = ^sdram_addr;

    // Any bank open blocks LOAD MODE and AUTO REFRESH.
    always_comb begin
        any_open = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bank_q[i] == BANK_OPEN) any_open = 1'b1;
        end
    end

    // Bank tracking, mode register, refresh count and first-error capture.
    always_comb begin
        bank_d       = bank_q;
        row_d        = row_q;
        mode_valid_d = mode_valid_q;
        mode_cl3_d   = mode_cl3_q;
        refresh_d    = refresh_q;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        raise        = 1'b0;
        raise_code   = 3'd0;
        for (int i = 0; i < 4; i++) begin
            age_d[i] = (age_q[i] == '1) ? age_q[i] : age_q[i] + 1'b1;
        end
        case (cmd)
            CMD_ACT: begin
                if (sel_open) begin
                    raise = 1'b1; raise_code = 3'd2;
                end else begin
                    bank_d[sdram_ba] = BANK_OPEN;
                    row_d[sdram_ba]  = sdram_addr[ROW_W-1:0];
                    age_d[sdram_ba]  = '0;
                end
            end
            CMD_RD: begin
                if (!sel_open) begin
                    raise = 1'b1; raise_code = 3'd1;
                end else if (!mode_valid_q) begin
                    raise = 1'b1; raise_code = 3'd3;
                end else begin
                    rd_en = 1'b1;
                    if (!age_ok) begin
                        raise = 1'b1; raise_code = 3'd6;
                    end
                    if (sdram_addr[10]) bank_d[sdram_ba] = BANK_CLOSED;
                end
            end
            CMD_WR: begin
                if (!sel_open) begin
                    raise = 1'b1; raise_code = 3'd1;
                end else begin
                    wr_en = 1'b1;
                    if (dq_oe_q) begin
                        raise = 1'b1; raise_code = 3'd5;
                    end else if (!age_ok) begin
                        raise = 1'b1; raise_code = 3'd6;
                    end
                    if (sdram_addr[10]) bank_d[sdram_ba] = BANK_CLOSED;
                end
            end
            CMD_PRE: begin
                if (sdram_addr[10]) begin
                    for (int i = 0; i < 4; i++) bank_d[i] = BANK_CLOSED;
                end else begin
                    bank_d[sdram_ba] = BANK_CLOSED;
                end
            end
            CMD_REF: begin
                refresh_d = refresh_q + 16'd1;
                if (any_open) begin
                    raise = 1'b1; raise_code = 3'd4;
                end
            end
            CMD_LMR: begin
                if (any_open) begin
                    raise = 1'b1; raise_code = 3'd4;
                end else if (lm_legal) begin
                    mode_valid_d = 1'b1;
                    mode_cl3_d   = sdram_addr[4];
                end else begin
                    raise = 1'b1; raise_code = 3'd3;
                end
            end
            default: ;
        endcase
        err_d      = err_q | raise;
        err_code_d = (raise && !err_q) ? raise_code : err_code_q;
    end

    // Read pipeline; each stage carries the CL it was issued under.
    always_comb begin
        pv_d[0]   = rd_en;
        pd_d[0]   = rd_en ? rd_word : 16'h0000;
        pcl3_d[0] = mode_cl3_q;
        pv_d[2:1]   = pv_q[1:0];
        pcl3_d[2:1] = pcl3_q[1:0];
        pd_d[1]     = pd_q[0];
        pd_d[2]     = pd_q[1];
        dq_oe_d = 1'b0;
        dq_o_d  = 16'h0000;
        if (pv_d[2] && pcl3_d[2]) begin
            dq_oe_d = 1'b1;
            dq_o_d  = pd_d[2];
        end else if (pv_d[1] && !pcl3_d[1]) begin
            dq_oe_d = 1'b1;
            dq_o_d  = pd_d[1];
        end
    end

    // State registers; reset also kills in-flight read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= BANK_CLOSED;
                row_q[i]  <= '0;
                age_q[i]  <= '0;
            end
            for (int i = 0; i < 3; i++) pd_q[i] <= 16'h0000;
            mode_valid_q <= 1'b0;
            mode_cl3_q   <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 3'd0;
            refresh_q    <= 16'h0000;
            pv_q         <= 3'b000;
            pcl3_q       <= 3'b000;
            dq_oe_q      <= 1'b0;
            dq_o_q       <= 16'h0000;
        end else begin
            bank_q       <= bank_d;
            row_q        <= row_d;
            age_q        <= age_d;
            pd_q         <= pd_d;
            mode_valid_q <= mode_valid_d;
            mode_cl3_q   <= mode_cl3_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            refresh_q    <= refresh_d;
            pv_q         <= pv_d;
            pcl3_q       <= pcl3_d;
            dq_oe_q      <= dq_oe_d;
            dq_o_q       <= dq_o_d;
        end
    end

    // Array write with per-byte masks; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!sdram_dqm[0]) mem_q[idx][7:0]  <= sdram_dq_i[7:0];
            if (!sdram_dqm[1]) mem_q[idx][15:8] <= sdram_dq_i[15:8];
        end
    end

    assign sdram_dq_o  = dq_o_q;
    assign sdram_dq_oe = dq_oe_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign refresh_cnt = refresh_q;

endmodule
